// File: rtl/p3_4_if.sv
// Serial-in / 2-bit-out signal bundle for the p3_4 Mealy controller.
// The package carries the state type so that other scopes can name state codes.
package p3_4_pkg;
  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_BAD = 2'b10,
    S_C   = 2'b11
  } state_e;
endpackage

interface p3_4_if;
  logic x;
  logic y;
  logic z;

  modport master (output x, input y, input z);
  modport slave  (input x, output y, output z);
endinterface

// File: rtl/p3_4.sv
// Three-state Mealy FSM: consumes one serial bit per cycle and produces {y,z}
// combinationally from the current state and the current input bit.
module p3_4
  import p3_4_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  p3_4_if.slave  io
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_A;
    else     state_q <= state_d;
  end

  // The unused code falls through to A so the machine can never lock up.
  always_comb begin
    state_d = S_A;
    case (state_q)
      S_A:     state_d = io.x ? S_C : S_B;
      S_B:     state_d = io.x ? S_C : S_B;
      S_C:     state_d = io.x ? S_C : S_A;
      default: state_d = S_A;
    endcase
  end

  // The unused code shares A's outputs: y follows x, z held high.
  always_comb begin
    io.y = io.x;
    io.z = 1'b1;
    case (state_q)
      S_B: begin
        io.y = 1'b1;
        io.z = 1'b0;
      end
      S_C: begin
        io.y = ~io.x;
        io.z = io.x;
      end
      default: begin
        io.y = io.x;
        io.z = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_p3_4.sv
// Self-checking bench for p3_4: table-driven reference model feeding a
// scoreboard of expected {y,z} codes that are popped at each mid-cycle sample.
module tb_p3_4;
  import p3_4_pkg::*;

  logic clk;
  logic rst;
  p3_4_if io();

  p3_4 dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [1:0] exp_q[$];
  logic [1:0] ms;
  logic [1:0] ns_tbl  [8];
  logic [1:0] out_tbl [8];

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(out_tbl[{ms, io.x}]);
  endtask

  task automatic pop_check(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 2'bxx, 2'b00);
    end else begin
      e = exp_q.pop_front();
      check(tag, {io.y, io.z}, e);
    end
  endtask

  // Mid-cycle input change: output must react with no clock edge.
  task automatic set_x(input logic v, input string tag);
    io.x = v;
    push_exp();
    #1;
    pop_check(tag);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    ms = rst ? 2'b00 : ns_tbl[{ms, io.x}];
    #2;
    push_exp();
    pop_check(tag);
    check({tag, "_st"}, dut.state_q, ms);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // index is {state, x}
    ns_tbl  = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    out_tbl = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    ms   = 2'b00;
    rst  = 1'b1;
    io.x = 1'b1;

    @(negedge clk);
    tick("rst_a_x1");
    rst = 1'b0;
    tick("a_to_c");
    set_x(1'b0, "c_x0");
    tick("c_to_a");

    tick("a_to_b");
    tick("b_to_b");
    set_x(1'b1, "b_x1");
    tick("b_to_c");

    for (int i = 0; i < 3; i++) tick("hold_c");
    set_x(1'b0, "c_x0_nowait");

    set_x(1'b1, "mealy_c_x1");
    set_x(1'b0, "mealy_c_x0");
    tick("mealy_to_a");
    set_x(1'b1, "mealy_a_x1");
    set_x(1'b0, "mealy_a_x0");
    tick("mealy_to_b");
    set_x(1'b1, "mealy_b_x1");
    set_x(1'b0, "mealy_b_x0");

    rst = 1'b1;
    set_x(1'b0, "rst_pending_b");
    tick("rst_to_a");
    rst = 1'b0;
    set_x(1'b1, "post_rst_a_x1");
    tick("post_rst_to_c");

    rst = 1'b1;
    tick("rst_from_c_x1");
    rst = 1'b0;

    for (int v = 0; v < 2; v++) begin
      force dut.state_q = S_BAD;
      ms = 2'b10;
      set_x(1'b0, "bad_x0");
      set_x(1'b1, "bad_x1");
      set_x(v[0], "bad_xsel");
      release dut.state_q;
      tick("bad_recover");
    end

    if (exp_q.size() != 0) check("sb_leftover", 2'b11, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
